// File: rtl/pc_unit_pkg.sv
// Shared state encodings and constants for the program-counter stage.
// No logic; pure type and constant definitions.
// No flow control.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_unit_add32.sv
// 32-bit ripple-free adder with carry in/out, shared by the PC incrementer and branch target path.
// Latency: combinational.
// No flow control.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC select (seq/branch/jump/jr), boot delay, halt/resume and misalignment trap.
// Latency: pc updates one cycle after the select inputs; pc_plus4 and fetch_valid are combinational.
// Backpressure: stall freezes pc in RUN; halt parks the stage until resume.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BOOT_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        misaligned,
    output logic [1:0]  state
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;

    logic [31:0] br_target;
    logic [31:0] next_pc;
    logic        inc_c_out;
    logic        br_c_out;
    logic        unused_bits;

    add32 u_inc (
        .a     (pc_q),
        .b     (PC_INC),
        .c_in  (1'b0),
        .sum   (pc_plus4),
        .c_out (inc_c_out)
    );

    // Offset is a word count; its top two bits fall off the shift.
    add32 u_br (
        .a     (pc_plus4),
        .b     ({branch_offset[29:0], 2'b00}),
        .c_in  (1'b0),
        .sum   (br_target),
        .c_out (br_c_out)
    );

    assign unused_bits = ^{inc_c_out, br_c_out, branch_offset[31:30]};

    always_comb begin
        next_pc = pc_plus4;
        if (jr)
            next_pc = jr_target;
        else if (jump)
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        else if (branch_taken)
            next_pc = br_target;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        case (state_q)
            ST_BOOT: begin
                if (cnt_q == 4'd0)
                    state_d = ST_RUN;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (!stall) begin
                    // Only jr can produce an unaligned target; trap without moving pc.
                    if (next_pc[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                    mis_d   = 1'b0;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= BOOT_INIT;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == ST_RUN);
    assign misaligned  = mis_q;
    assign state       = state_q;

endmodule
